l2_cache: RTL and testbench

// - Synthesizable unified L2 cache, directly downstream of L1_Data_Cache; serves its l2_* request/ready port.
// - 4-way set-associative, write-back, write-allocate, true-LRU; backed by main memory via a mem_* request/ready port.
// - One outstanding transaction at a time on each side.

---
 rtl/l2_cache_pkg.sv | 33 +++
 rtl/l2_cache_if.sv | 36 +++
 rtl/l2_way_select.sv | 70 +++++++
 rtl/l2_cache.sv | 227 ++++++++++++++++++++++
 tb/tb_l2_cache.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: geometry, FSM state type and per-line metadata record for
// the unified 4-way set-associative L2 cache (one 32-bit word per line).
package l2_cache_pkg;

    localparam int CACHE_SIZE    = 16384;
    localparam int BLOCK_SIZE    = 4;
    localparam int ASSOCIATIVITY = 4;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;

    localparam int NUM_SETS    = CACHE_SIZE / (BLOCK_SIZE * ASSOCIATIVITY);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS    = $clog2(ASSOCIATIVITY);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } l2_state_e;

    // lru_age: 0 = most recently used, 3 = least recently used
    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
        logic [1:0]          lru_age;
    } line_meta_t;

endpackage

// File: rtl/l2_cache_if.sv
// l2_cache_if: bundles the L1-facing request/ready port (l2_*) and the
// memory-facing request/ready port (mem_*) of the L2 cache.
//   slave  : view taken by the cache itself
//   master : view taken by the environment (L1 + main memory)
interface l2_cache_if;
    import l2_cache_pkg::*;

    logic                  l2_request;
    logic                  l2_write_enable;
    logic [ADDR_WIDTH-1:0] l2_address;
    logic [DATA_WIDTH-1:0] l2_write_data;
    logic [DATA_WIDTH-1:0] l2_response_data;
    logic                  l2_ready;

    logic                  mem_request;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_response_data;
    logic                  mem_ready;

    modport slave (
        input  l2_request, l2_write_enable, l2_address, l2_write_data,
               mem_response_data, mem_ready,
        output l2_response_data, l2_ready,
               mem_request, mem_write_enable, mem_address, mem_write_data
    );

    modport master (
        output l2_request, l2_write_enable, l2_address, l2_write_data,
               mem_response_data, mem_ready,
        input  l2_response_data, l2_ready,
               mem_request, mem_write_enable, mem_address, mem_write_data
    );

endinterface

// File: rtl/l2_way_select.sv
// l2_way_select: combinational hit/victim/LRU logic for one set.
//   meta_i        : metadata of the four ways of the addressed set
//   tag_i         : tag being looked up
//   hit_o         : tag present in a valid way
//   hit_way_o     : way holding the tag
//   victim_way_o  : lowest-index invalid way, else the LRU (oldest) way
//   victim_dirty_o: victim holds modified data
//   lru_next_o    : age vector after touching hit_way (hit) or victim_way (miss)
module l2_way_select
    import l2_cache_pkg::*;
(
    input  line_meta_t [ASSOCIATIVITY-1:0]      meta_i,
    input  logic [TAG_BITS-1:0]                 tag_i,
    output logic                                hit_o,
    output logic [WAY_BITS-1:0]                 hit_way_o,
    output logic [WAY_BITS-1:0]                 victim_way_o,
    output logic                                victim_dirty_o,
    output logic [ASSOCIATIVITY-1:0][1:0]       lru_next_o
);

    logic                touched_valid;
    logic [WAY_BITS-1:0] touched_way;
    logic [1:0]          old_age;
    logic                found_invalid;
    logic [1:0]          max_age;

    always_comb begin
        hit_o         = 1'b0;
        hit_way_o     = '0;
        found_invalid = 1'b0;
        victim_way_o  = '0;
        max_age       = meta_i[0].lru_age;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (!hit_o && meta_i[w].valid && meta_i[w].tag == tag_i) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_BITS'(w);
            end
        end
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (!found_invalid && !meta_i[w].valid) begin
                found_invalid = 1'b1;
                victim_way_o  = WAY_BITS'(w);
            end
        end
        if (!found_invalid) begin
            // strict '>' keeps the lowest index on ties
            for (int w = 1; w < ASSOCIATIVITY; w++) begin
                if (meta_i[w].lru_age > max_age) begin
                    max_age      = meta_i[w].lru_age;
                    victim_way_o = WAY_BITS'(w);
                end
            end
        end
    end

    assign victim_dirty_o = meta_i[victim_way_o].valid && meta_i[victim_way_o].dirty;
    assign touched_way    = hit_o ? hit_way_o : victim_way_o;
    assign touched_valid  = meta_i[touched_way].valid;
    // An empty way being filled counts as oldest, so every valid way ages
    // by one and the set converges to a 0..3 permutation once full.
    assign old_age        = touched_valid ? meta_i[touched_way].lru_age : 2'd3;

    for (genvar gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_lru
        assign lru_next_o[gi] =
            (WAY_BITS'(gi) == touched_way)                          ? 2'd0 :
            (meta_i[gi].valid && meta_i[gi].lru_age < old_age)      ? meta_i[gi].lru_age + 2'd1 :
                                                                      meta_i[gi].lru_age;
    end

endmodule

// File: rtl/l2_cache.sv
// l2_cache: unified 4-way set-associative, write-back, write-allocate L2
// cache with true LRU, one word per line, one transaction at a time.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (aborts any transaction)
//   bus   : l2_* request/ready port toward L1, mem_* request/ready port
//           toward main memory (see l2_cache_if)
module l2_cache
    import l2_cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    l2_cache_if.slave  bus
);

    l2_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] index_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  ready_q, ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [ASSOCIATIVITY-1:0]      valid_q [NUM_SETS];
    logic [ASSOCIATIVITY-1:0]      dirty_q [NUM_SETS];
    logic [ASSOCIATIVITY-1:0][1:0] lru_q   [NUM_SETS];

    logic [TAG_BITS-1:0]   rd_tag  [ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0] rd_data [ASSOCIATIVITY];

    line_meta_t [ASSOCIATIVITY-1:0] set_meta;
    logic                           hit, victim_dirty;
    logic [WAY_BITS-1:0]            hit_way, victim_way;
    logic [ASSOCIATIVITY-1:0][1:0]  lru_next;

    logic                  capture;
    logic [INDEX_BITS-1:0] cap_index;
    logic                  wr_en;
    logic [WAY_BITS-1:0]   wr_way;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  meta_we;
    logic [WAY_BITS-1:0]   meta_way;
    logic                  meta_dirty;
    logic                  unused_offset_bits;

    // the byte offset inside the single-word line carries no information
    assign unused_offset_bits = ^bus.l2_address[OFFSET_BITS-1:0];

    assign capture   = (state_q == IDLE) && bus.l2_request && !ready_q;
    assign cap_index = bus.l2_address[OFFSET_BITS +: INDEX_BITS];

    // Tag/data storage: one RAM per way, read in the capture cycle so the
    // whole set is available in LOOKUP; writes always target the captured set.
    for (genvar gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_way
        logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
        logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];
        logic [TAG_BITS-1:0]   rd_tag_q;
        logic [DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk) begin
            if (wr_en && wr_way == WAY_BITS'(gi)) begin
                tag_mem[index_q]  <= tag_q;
                data_mem[index_q] <= wr_data;
            end
            if (capture) begin
                rd_tag_q  <= tag_mem[cap_index];
                rd_data_q <= data_mem[cap_index];
            end
        end

        assign rd_tag[gi]   = rd_tag_q;
        assign rd_data[gi]  = rd_data_q;
        assign set_meta[gi] = {valid_q[index_q][gi], dirty_q[index_q][gi],
                               rd_tag_q, lru_q[index_q][gi]};
    end

    l2_way_select u_way_select (
        .meta_i         (set_meta),
        .tag_i          (tag_q),
        .hit_o          (hit),
        .hit_way_o      (hit_way),
        .victim_way_o   (victim_way),
        .victim_dirty_o (victim_dirty),
        .lru_next_o     (lru_next)
    );

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        ready_d     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en       = 1'b0;
        wr_way      = victim_way;
        wr_data     = wdata_q;
        meta_we     = 1'b0;
        meta_way    = victim_way;
        meta_dirty  = 1'b1;

        case (state_q)
            IDLE: begin
                if (capture) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    wr_en      = we_q;
                    wr_way     = hit_way;
                    meta_we    = 1'b1;
                    meta_way   = hit_way;
                    meta_dirty = dirty_q[index_q][hit_way] | we_q;
                    resp_d     = we_q ? wdata_q : rd_data[hit_way];
                    ready_d    = 1'b1;
                    state_d    = RESPOND;
                end else if (victim_dirty) begin
                    state_d = WRITEBACK;
                end else if (!we_q) begin
                    state_d = FILL;
                end else begin
                    // clean write miss: allocate without touching memory
                    wr_en   = 1'b1;
                    meta_we = 1'b1;
                    resp_d  = wdata_q;
                    ready_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            WRITEBACK: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_tag[victim_way], index_q, {OFFSET_BITS{1'b0}}};
                    mem_wdata_d = rd_data[victim_way];
                end else if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (we_q) begin
                        wr_en   = 1'b1;
                        meta_we = 1'b1;
                        resp_d  = wdata_q;
                        ready_d = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag_q, index_q, {OFFSET_BITS{1'b0}}};
                end else if (bus.mem_ready) begin
                    mem_req_d  = 1'b0;
                    wr_en      = 1'b1;
                    wr_data    = bus.mem_response_data;
                    meta_we    = 1'b1;
                    meta_dirty = 1'b0;
                    resp_d     = bus.mem_response_data;
                    ready_d    = 1'b1;
                    state_d    = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tag_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            resp_q      <= '0;
            ready_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (capture) begin
                index_q <= cap_index;
                tag_q   <= bus.l2_address[ADDR_WIDTH-1 -: TAG_BITS];
                we_q    <= bus.l2_write_enable;
                wdata_q <= bus.l2_write_data;
            end
        end
    end

    // installs happen in the completing cycle, so an abort leaves no trace
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else if (meta_we) begin
            valid_q[index_q][meta_way] <= 1'b1;
            dirty_q[index_q][meta_way] <= meta_dirty;
            lru_q[index_q]             <= lru_next;
        end
    end

    assign bus.l2_ready         = ready_q;
    assign bus.l2_response_data = resp_q;
    assign bus.mem_request      = mem_req_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed testbench for l2_cache with a simple main-memory
// responder that answers each mem_request after a fixed delay.
module tb_l2_cache;
    import l2_cache_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2_cache_if bus();

    l2_cache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          mem_req_count = 0;
    int          mem_delay = 3;
    logic [31:0] fill_word = 32'h0;
    logic [31:0] log_addr [16];
    logic        log_we   [16];
    logic [31:0] log_wd   [16];

    // main memory: log every request, answer with fill_word after mem_delay
    initial begin
        bus.mem_ready         = 1'b0;
        bus.mem_response_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_request === 1'b1) begin
                log_addr[mem_req_count % 16] = bus.mem_address;
                log_we[mem_req_count % 16]   = bus.mem_write_enable;
                log_wd[mem_req_count % 16]   = bus.mem_write_data;
                mem_req_count++;
                repeat (mem_delay - 1) @(posedge clk);
                #1;
                bus.mem_ready         = 1'b1;
                bus.mem_response_data = bus.mem_write_enable ? 32'h0 : fill_word;
                @(posedge clk);
                #1;
                bus.mem_ready         = 1'b0;
                bus.mem_response_data = 32'h0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.l2_request = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // one L1 transaction; cyc = negedges until l2_ready seen, nreq = memory requests issued
    task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc, output int nreq);
        int base;
        @(negedge clk);
        base                = mem_req_count;
        bus.l2_request      = 1'b1;
        bus.l2_write_enable = we;
        bus.l2_address      = a;
        bus.l2_write_data   = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.l2_ready !== 1'b1 && cyc < 60);
        rd   = bus.l2_response_data;
        nreq = mem_req_count - base;
        bus.l2_request = 1'b0;
        tests_run++;
        if (bus.l2_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_timeout addr=%h: l2_ready=%b, required 1 within 60 cycles", a, bus.l2_ready);
        end
        $display("[TB] %s addr=%h wdata=%h -> rdata=%h cycles=%0d mem_requests=%0d",
                 we ? "WR" : "RD", a, wd, rd, cyc, nreq);
    endtask

    task automatic test_reset();
        bus.l2_request      = 1'b0;
        bus.l2_write_enable = 1'b0;
        bus.l2_address      = 32'h0;
        bus.l2_write_data   = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run += 6;
        if (bus.l2_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_l2_ready got=%b exp=0", bus.l2_ready); end
        if (bus.l2_response_data !== 32'h0) begin tests_failed++; $display("FAIL reset_resp got=%h exp=0", bus.l2_response_data); end
        if (bus.mem_request !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_request got=%b exp=0", bus.mem_request); end
        if (bus.mem_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_write_enable); end
        if (bus.mem_address !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_address); end
        if (bus.mem_write_data !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_write_data); end
        $display("[TB] reset state checked");
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        int cyc, n, b;
        fill_word = 32'hAAAAAAAA;
        b = mem_req_count;
        do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 4;
        if (rd !== 32'hAAAAAAAA) begin tests_failed++; $display("FAIL cold_read_data got=%h exp=AAAAAAAA", rd); end
        if (n !== 1) begin tests_failed++; $display("FAIL cold_read_mem_count got=%0d exp=1", n); end
        if (log_addr[b % 16] !== 32'h00000800) begin tests_failed++; $display("FAIL cold_fill_addr got=%h exp=00000800", log_addr[b % 16]); end
        if (log_we[b % 16] !== 1'b0) begin tests_failed++; $display("FAIL cold_fill_we got=%b exp=0", log_we[b % 16]); end
        do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 3;
        if (rd !== 32'hAAAAAAAA) begin tests_failed++; $display("FAIL reread_data got=%h exp=AAAAAAAA", rd); end
        if (cyc !== 2) begin tests_failed++; $display("FAIL hit_latency got=%0d exp=2", cyc); end
        if (n !== 0) begin tests_failed++; $display("FAIL reread_mem_count got=%0d exp=0", n); end
    endtask

    // fills set 512 with tags 00000/ABCDE/AAAAA/FFFFF into ways 0..3
    task automatic fill_set512(output int total);
        logic [31:0] rd;
        int cyc, n;
        total = 0;
        fill_word = 32'h10000000; do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n); total += n;
        fill_word = 32'h10000001; do_req(32'hABCDE802, 1'b0, 32'h0, rd, cyc, n); total += n;
        fill_word = 32'h10000002; do_req(32'hAAAAA802, 1'b0, 32'h0, rd, cyc, n); total += n;
        fill_word = 32'h10000003; do_req(32'hFFFFF802, 1'b0, 32'h0, rd, cyc, n); total += n;
    endtask

    task automatic test_lru_victim();
        logic [31:0] rd;
        int cyc, n, b, total;
        apply_reset();
        fill_set512(total);
        tests_run += 1;
        if (total !== 4) begin tests_failed++; $display("FAIL lru_fill_count got=%0d exp=4", total); end
        do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 2;
        if (n !== 0) begin tests_failed++; $display("FAIL lru_rehit_mem_count got=%0d exp=0", n); end
        if (rd !== 32'h10000000) begin tests_failed++; $display("FAIL lru_rehit_data got=%h exp=10000000", rd); end
        fill_word = 32'h22223333;
        b = mem_req_count;
        do_req(32'h12345802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 4;
        if (n !== 1) begin tests_failed++; $display("FAIL lru_evict_mem_count got=%0d exp=1", n); end
        if (log_we[b % 16] !== 1'b0) begin tests_failed++; $display("FAIL lru_evict_we got=%b exp=0", log_we[b % 16]); end
        if (log_addr[b % 16] !== 32'h12345800) begin tests_failed++; $display("FAIL lru_evict_addr got=%h exp=12345800", log_addr[b % 16]); end
        if (rd !== 32'h22223333) begin tests_failed++; $display("FAIL lru_evict_data got=%h exp=22223333", rd); end
        do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 1;
        if (n !== 0) begin tests_failed++; $display("FAIL lru_keep_mru got=%0d mem requests exp=0", n); end
        do_req(32'hABCDE802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 1;
        if (n !== 1) begin tests_failed++; $display("FAIL lru_victim_was_abcde got=%0d mem requests exp=1", n); end
    endtask

    task automatic test_write_evict();
        logic [31:0] rd;
        int cyc, n, b, total;
        apply_reset();
        fill_set512(total);
        do_req(32'hABCDE802, 1'b1, 32'hBEEFDEAD, rd, cyc, n);
        tests_run += 3;
        if (n !== 0) begin tests_failed++; $display("FAIL write_hit_mem_count got=%0d exp=0", n); end
        if (rd !== 32'hBEEFDEAD) begin tests_failed++; $display("FAIL write_hit_resp got=%h exp=BEEFDEAD", rd); end
        if (cyc !== 2) begin tests_failed++; $display("FAIL write_hit_latency got=%0d exp=2", cyc); end
        do_req(32'h00000802, 1'b0, 32'h0, rd, cyc, n);
        do_req(32'hAAAAA802, 1'b0, 32'h0, rd, cyc, n);
        do_req(32'hFFFFF802, 1'b0, 32'h0, rd, cyc, n);
        fill_word = 32'h55551234;
        b = mem_req_count;
        do_req(32'h12345802, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 7;
        if (n !== 2) begin tests_failed++; $display("FAIL evict_mem_count got=%0d exp=2", n); end
        if (log_we[b % 16] !== 1'b1) begin tests_failed++; $display("FAIL wb_we got=%b exp=1", log_we[b % 16]); end
        if (log_addr[b % 16] !== 32'hABCDE800) begin tests_failed++; $display("FAIL wb_addr got=%h exp=ABCDE800", log_addr[b % 16]); end
        if (log_wd[b % 16] !== 32'hBEEFDEAD) begin tests_failed++; $display("FAIL wb_data got=%h exp=BEEFDEAD", log_wd[b % 16]); end
        if (log_we[(b + 1) % 16] !== 1'b0) begin tests_failed++; $display("FAIL post_wb_fill_we got=%b exp=0", log_we[(b + 1) % 16]); end
        if (log_addr[(b + 1) % 16] !== 32'h12345800) begin tests_failed++; $display("FAIL post_wb_fill_addr got=%h exp=12345800", log_addr[(b + 1) % 16]); end
        if (rd !== 32'h55551234) begin tests_failed++; $display("FAIL post_wb_data got=%h exp=55551234", rd); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd;
        int cyc, n;
        do_req(32'h00000FFC, 1'b1, 32'h12345678, rd, cyc, n);
        tests_run += 2;
        if (n !== 0) begin tests_failed++; $display("FAIL write_miss_mem_count got=%0d exp=0", n); end
        if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL write_miss_resp got=%h exp=12345678", rd); end
        do_req(32'h00000FFC, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 3;
        if (n !== 0) begin tests_failed++; $display("FAIL write_miss_reread_mem got=%0d exp=0", n); end
        if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL write_miss_reread_data got=%h exp=12345678", rd); end
        if (cyc !== 2) begin tests_failed++; $display("FAIL write_miss_reread_latency got=%0d exp=2", cyc); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int cyc, n, waited;
        fill_word = 32'h77777777;
        @(negedge clk);
        bus.l2_request      = 1'b1;
        bus.l2_write_enable = 1'b0;
        bus.l2_address      = 32'h00001230;
        waited = 0;
        while (bus.mem_request !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run += 1;
        if (bus.mem_request !== 1'b1) begin tests_failed++; $display("FAIL mid_fill_request got=%b exp=1", bus.mem_request); end
        reset = 1'b1;
        #1;
        tests_run += 2;
        if (bus.mem_request !== 1'b0) begin tests_failed++; $display("FAIL abort_mem_request got=%b exp=0", bus.mem_request); end
        if (bus.l2_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_l2_ready got=%b exp=0", bus.l2_ready); end
        bus.l2_request = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        fill_word = 32'h0BADF00D;
        do_req(32'h00001230, 1'b0, 32'h0, rd, cyc, n);
        tests_run += 2;
        if (n !== 1) begin tests_failed++; $display("FAIL after_abort_miss got=%0d mem requests exp=1", n); end
        if (rd !== 32'h0BADF00D) begin tests_failed++; $display("FAIL after_abort_data got=%h exp=0BADF00D", rd); end
    endtask

    // request held high: hit read repeats every 3 cycles (LOOKUP, RESPOND, IDLE)
    task automatic test_back_to_back();
        int pulses, first, last, bad_gap, bad_data, base;
        pulses = 0; first = 0; last = 0; bad_gap = 0; bad_data = 0;
        @(negedge clk);
        base                = mem_req_count;
        bus.l2_request      = 1'b1;
        bus.l2_write_enable = 1'b0;
        bus.l2_address      = 32'h00001230;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.l2_ready === 1'b1) begin
                pulses++;
                if (pulses == 1) first = i;
                else if (i - last != 3) bad_gap++;
                if (bus.l2_response_data !== 32'h0BADF00D) bad_data++;
                last = i;
                $display("[TB] held RD addr=00001230 ready at cycle %0d rdata=%h", i, bus.l2_response_data);
            end
        end
        bus.l2_request = 1'b0;
        tests_run += 5;
        if (pulses !== 4) begin tests_failed++; $display("FAIL held_pulse_count got=%0d exp=4", pulses); end
        if (first !== 2) begin tests_failed++; $display("FAIL held_first_pulse got=%0d exp=2", first); end
        if (bad_gap !== 0) begin tests_failed++; $display("FAIL held_pulse_spacing bad_gaps=%0d exp=0", bad_gap); end
        if (bad_data !== 0) begin tests_failed++; $display("FAIL held_data bad=%0d exp=0", bad_data); end
        if (mem_req_count - base !== 0) begin tests_failed++; $display("FAIL held_mem_count got=%0d exp=0", mem_req_count - base); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_lru_victim();
        test_write_evict();
        test_write_miss();
        test_reset_mid_fill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
